// File: rtl/channel_request_arbiter_pkg.sv
// Shared definitions for channel_request_arbiter: operation codes,
// arbiter state encoding and default field widths.
package channel_request_arbiter_pkg;

  localparam int CRA_ADDR_BITS = 8;

  localparam int CRA_DATA_BITS = 16;

  typedef enum logic [3:0] {
    OP_NOP            = 4'd0,
    OP_CREATE_CHANNEL = 4'd1,
    OP_DESTROY_CHANNEL= 4'd2,
    OP_SEND           = 4'd3,
    OP_RECEIVE        = 4'd4,
    OP_ALT_START      = 4'd5,
    OP_ALT_WAIT       = 4'd6,
    OP_ALT_END        = 4'd7,
    OP_ENABLE_CHANNEL = 4'd8,
    OP_DISABLE_CHANNEL= 4'd9
  } chan_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/channel_request_arbiter_rr_priority_picker.sv
// Combinational find-first-set starting at a rotating pointer.
// Returns a one-hot grant, its index and an any-request flag.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan N positions cyclically from ptr, keep the first hit
  always_comb begin
    int k;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/channel_request_arbiter.sv
// Round-robin arbiter sharing one ChannelController among cores.
// Optional wait timeout: define CHANNEL_ARB_TIMEOUT_EN.
module channel_request_arbiter
  import channel_request_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_BITS = CRA_ADDR_BITS,
  parameter int DATA_BITS = CRA_DATA_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef CHANNEL_ARB_TIMEOUT_EN
  output logic                           timeout_err,
`endif
  input  logic [NUM_CORES-1:0]           req_valid,
  input  logic [4*NUM_CORES-1:0]         req_op,
  input  logic [ADDR_BITS*NUM_CORES-1:0] req_channel,
  input  logic [DATA_BITS*NUM_CORES-1:0] req_message,
  input  logic [ADDR_BITS*NUM_CORES-1:0] req_pid,
  input  logic [NUM_CORES-1:0]           req_rx_had_msg,
  output logic [NUM_CORES-1:0]           req_accept,
  output logic [NUM_CORES-1:0]           resp_valid,
  output logic                           resp_has_channel,
  output logic                           resp_has_message,
  output logic                           resp_has_schedule,
  output logic                           resp_has_deschedule,
  output logic                           resp_rx_has_msg_in_alt,
  output logic [ADDR_BITS-1:0]           resp_channel,
  output logic [DATA_BITS-1:0]           resp_message,
  output logic [ADDR_BITS-1:0]           resp_schedule_pid,
  output logic [ADDR_BITS-1:0]           resp_deschedule_pid,
  output logic                           busy,
  output logic                           cc_enabled,
  output logic [3:0]                     cc_op,
  output logic [ADDR_BITS-1:0]           cc_channel,
  output logic [ADDR_BITS-1:0]           cc_pid,
  output logic [DATA_BITS-1:0]           cc_message,
  output logic                           cc_rx_had_msg,
  input  logic                           cc_finished,
  input  logic                           cc_has_channel,
  input  logic                           cc_has_message,
  input  logic                           cc_has_schedule,
  input  logic                           cc_has_deschedule,
  input  logic                           cc_rx_has_msg,
  input  logic [ADDR_BITS-1:0]           cc_channel_out,
  input  logic [ADDR_BITS-1:0]           cc_schedule_pid,
  input  logic [ADDR_BITS-1:0]           cc_deschedule_pid,
  input  logic [DATA_BITS-1:0]           cc_message_out
);

  localparam int IW = $clog2(NUM_CORES);

  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;

  logic [3:0]           op_q, op_d;
  logic [ADDR_BITS-1:0] chan_q, chan_d;
  logic [ADDR_BITS-1:0] pid_q, pid_d;
  logic [DATA_BITS-1:0] msg_q, msg_d;
  logic                 rx_q, rx_d;

  logic                 r_hc_q, r_hc_d;
  logic                 r_hm_q, r_hm_d;
  logic                 r_hs_q, r_hs_d;
  logic                 r_hd_q, r_hd_d;
  logic                 r_rx_q, r_rx_d;
  logic [ADDR_BITS-1:0] r_ch_q, r_ch_d;
  logic [DATA_BITS-1:0] r_msg_q, r_msg_d;
  logic [ADDR_BITS-1:0] r_sp_q, r_sp_d;
  logic [ADDR_BITS-1:0] r_dp_q, r_dp_d;

`ifdef CHANNEL_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        to_err_q, to_err_d;
`endif

  logic [NUM_CORES-1:0] pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  rr_priority_picker #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // next-state, request capture and result latching
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    chan_d   = chan_q;
    pid_d    = pid_q;
    msg_d    = msg_q;
    rx_d     = rx_q;
    r_hc_d   = r_hc_q;
    r_hm_d   = r_hm_q;
    r_hs_d   = r_hs_q;
    r_hd_d   = r_hd_q;
    r_rx_d   = r_rx_q;
    r_ch_d   = r_ch_q;
    r_msg_d  = r_msg_q;
    r_sp_d   = r_sp_q;
    r_dp_d   = r_dp_q;
`ifdef CHANNEL_ARB_TIMEOUT_EN
    to_cnt_d = '0;
    to_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          op_d    = req_op[int'(pick_idx)*4 +: 4];
          chan_d  = req_channel[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
          pid_d   = req_pid[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
          msg_d   = req_message[int'(pick_idx)*DATA_BITS +: DATA_BITS];
          rx_d    = req_rx_had_msg[pick_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      // finished may still be high from the previous op here
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cc_finished) begin
          r_hc_d  = cc_has_channel;
          r_hm_d  = cc_has_message;
          r_hs_d  = cc_has_schedule;
          r_hd_d  = cc_has_deschedule;
          r_rx_d  = cc_rx_has_msg;
          r_ch_d  = cc_channel_out;
          r_msg_d = cc_message_out;
          r_sp_d  = cc_schedule_pid;
          r_dp_d  = cc_deschedule_pid;
          state_d = ST_RESP;
        end
`ifdef CHANNEL_ARB_TIMEOUT_EN
        else if (to_cnt_q == 16'hFFFF) begin
          r_hc_d   = 1'b0;
          r_hm_d   = 1'b0;
          r_hs_d   = 1'b0;
          r_hd_d   = 1'b0;
          r_rx_d   = 1'b0;
          to_err_d = 1'b1;
          state_d  = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end
      ST_RESP: begin
        rr_ptr_d = (gnt_q == IW'(NUM_CORES - 1)) ? '0 : gnt_q + IW'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      op_q     <= '0;
      chan_q   <= '0;
      pid_q    <= '0;
      msg_q    <= '0;
      rx_q     <= 1'b0;
      r_hc_q   <= 1'b0;
      r_hm_q   <= 1'b0;
      r_hs_q   <= 1'b0;
      r_hd_q   <= 1'b0;
      r_rx_q   <= 1'b0;
      r_ch_q   <= '0;
      r_msg_q  <= '0;
      r_sp_q   <= '0;
      r_dp_q   <= '0;
`ifdef CHANNEL_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      chan_q   <= chan_d;
      pid_q    <= pid_d;
      msg_q    <= msg_d;
      rx_q     <= rx_d;
      r_hc_q   <= r_hc_d;
      r_hm_q   <= r_hm_d;
      r_hs_q   <= r_hs_d;
      r_hd_q   <= r_hd_d;
      r_rx_q   <= r_rx_d;
      r_ch_q   <= r_ch_d;
      r_msg_q  <= r_msg_d;
      r_sp_q   <= r_sp_d;
      r_dp_q   <= r_dp_d;
`ifdef CHANNEL_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
`endif
    end
  end

  // state-decoded handshakes; accept gated so reset forces it low
  always_comb begin
    req_accept = '0;
    resp_valid = '0;
    if (state_q == ST_IDLE && !reset) req_accept = pick_grant;
    if (state_q == ST_RESP) resp_valid = NUM_CORES'(1) << gnt_q;
  end

  assign busy       = (state_q != ST_IDLE);
  assign cc_enabled = (state_q == ST_ISSUE);

  assign cc_op         = op_q;
  assign cc_channel    = chan_q;
  assign cc_pid        = pid_q;
  assign cc_message    = msg_q;
  assign cc_rx_had_msg = rx_q;

  assign resp_has_channel       = r_hc_q;
  assign resp_has_message       = r_hm_q;
  assign resp_has_schedule      = r_hs_q;
  assign resp_has_deschedule    = r_hd_q;
  assign resp_rx_has_msg_in_alt = r_rx_q;
  assign resp_channel           = r_ch_q;
  assign resp_message           = r_msg_q;
  assign resp_schedule_pid      = r_sp_q;
  assign resp_deschedule_pid    = r_dp_q;

`ifdef CHANNEL_ARB_TIMEOUT_EN
  assign timeout_err = to_err_q;
`endif

endmodule

// File: tb/tb_channel_request_arbiter.sv
// Directed bench for channel_request_arbiter: vector table of single
// operations plus hand sequences for contention, abort and timeout.
module tb_channel_request_arbiter;
  import channel_request_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AB = CRA_ADDR_BITS;
  localparam int DB = CRA_DATA_BITS;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [4*N-1:0]  req_op;
  logic [AB*N-1:0] req_channel;
  logic [DB*N-1:0] req_message;
  logic [AB*N-1:0] req_pid;
  logic [N-1:0]    req_rx_had_msg;
  logic [N-1:0]    req_accept;
  logic [N-1:0]    resp_valid;
  logic            resp_has_channel, resp_has_message;
  logic            resp_has_schedule, resp_has_deschedule;
  logic            resp_rx_has_msg_in_alt;
  logic [AB-1:0]   resp_channel, resp_schedule_pid, resp_deschedule_pid;
  logic [DB-1:0]   resp_message;
  logic            busy, cc_enabled, cc_rx_had_msg;
  logic [3:0]      cc_op;
  logic [AB-1:0]   cc_channel, cc_pid;
  logic [DB-1:0]   cc_message;
  logic            cc_finished;
  logic            cc_has_channel, cc_has_message;
  logic            cc_has_schedule, cc_has_deschedule, cc_rx_has_msg;
  logic [AB-1:0]   cc_channel_out, cc_schedule_pid, cc_deschedule_pid;
  logic [DB-1:0]   cc_message_out;
`ifdef CHANNEL_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  channel_request_arbiter #(
    .NUM_CORES (N),
    .ADDR_BITS (AB),
    .DATA_BITS (DB)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
`ifdef CHANNEL_ARB_TIMEOUT_EN
    .timeout_err            (timeout_err),
`endif
    .req_valid              (req_valid),
    .req_op                 (req_op),
    .req_channel            (req_channel),
    .req_message            (req_message),
    .req_pid                (req_pid),
    .req_rx_had_msg         (req_rx_had_msg),
    .req_accept             (req_accept),
    .resp_valid             (resp_valid),
    .resp_has_channel       (resp_has_channel),
    .resp_has_message       (resp_has_message),
    .resp_has_schedule      (resp_has_schedule),
    .resp_has_deschedule    (resp_has_deschedule),
    .resp_rx_has_msg_in_alt (resp_rx_has_msg_in_alt),
    .resp_channel           (resp_channel),
    .resp_message           (resp_message),
    .resp_schedule_pid      (resp_schedule_pid),
    .resp_deschedule_pid    (resp_deschedule_pid),
    .busy                   (busy),
    .cc_enabled             (cc_enabled),
    .cc_op                  (cc_op),
    .cc_channel             (cc_channel),
    .cc_pid                 (cc_pid),
    .cc_message             (cc_message),
    .cc_rx_had_msg          (cc_rx_had_msg),
    .cc_finished            (cc_finished),
    .cc_has_channel         (cc_has_channel),
    .cc_has_message         (cc_has_message),
    .cc_has_schedule        (cc_has_schedule),
    .cc_has_deschedule      (cc_has_deschedule),
    .cc_rx_has_msg          (cc_rx_has_msg),
    .cc_channel_out         (cc_channel_out),
    .cc_schedule_pid        (cc_schedule_pid),
    .cc_deschedule_pid      (cc_deschedule_pid),
    .cc_message_out         (cc_message_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            core;
    logic [3:0]    op;
    logic [AB-1:0] chan;
    logic [DB-1:0] msg;
    logic [AB-1:0] pid;
    logic          rx;
    int            fin;
    bit            keep_fin;
    logic          hc, hm, hs, hd, hr;
    logic [AB-1:0] ch_o, s_pid, d_pid;
    logic [DB-1:0] m_o;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input vec_t v);
    req_op[4*v.core +: 4]        = v.op;
    req_channel[AB*v.core +: AB] = v.chan;
    req_message[DB*v.core +: DB] = v.msg;
    req_pid[AB*v.core +: AB]     = v.pid;
    req_rx_had_msg[v.core]       = v.rx;
    req_valid[v.core]            = 1'b1;
  endtask

  task automatic drive_cc(input vec_t v);
    cc_has_channel    = v.hc;
    cc_has_message    = v.hm;
    cc_has_schedule   = v.hs;
    cc_has_deschedule = v.hd;
    cc_rx_has_msg     = v.hr;
    cc_channel_out    = v.ch_o;
    cc_schedule_pid   = v.s_pid;
    cc_deschedule_pid = v.d_pid;
    cc_message_out    = v.m_o;
    cc_finished       = 1'b1;
  endtask

  // one full operation for v.core; acts as the controller model
  task automatic do_op(input vec_t v);
    int t;
    int exp_lat;
    bit got;
    logic [N-1:0] onehot;
    onehot  = N'(1) << v.core;
    exp_lat = ((v.fin > 3) ? v.fin : 3) + 1;
    got     = 1'b0;
    drive_req(v);
    if (v.fin == 0) drive_cc(v);
    #1;
    for (int w = 0; w < 8 && req_accept == '0; w++) step();
    check("accept", 64'(req_accept), 64'(onehot));
    for (t = 1; t <= 24 && !got; t++) begin
      step();
      if (t == 1) begin
        req_valid[v.core] = 1'b0;
        check("issue_en", 64'(cc_enabled), 64'd1);
        check("busy", 64'(busy), 64'd1);
        check("cc_op", 64'(cc_op), 64'(v.op));
        check("cc_chan", 64'(cc_channel), 64'(v.chan));
        check("cc_pid", 64'(cc_pid), 64'(v.pid));
        check("cc_rx", 64'(cc_rx_had_msg), 64'(v.rx));
      end
      if (t == 2) check("settle_en", 64'(cc_enabled), 64'd0);
      if (t == 3) check("cc_msg", 64'(cc_message), 64'(v.msg));
      if (t == v.fin) drive_cc(v);
      if (resp_valid != '0) begin
        got = 1'b1;
        check("latency", 64'(t), 64'(exp_lat));
        check("resp_valid", 64'(resp_valid), 64'(onehot));
        check("no_acc_resp", 64'(req_accept), 64'd0);
        check("r_hc", 64'(resp_has_channel), 64'(v.hc));
        check("r_hm", 64'(resp_has_message), 64'(v.hm));
        check("r_hs", 64'(resp_has_schedule), 64'(v.hs));
        check("r_hd", 64'(resp_has_deschedule), 64'(v.hd));
        check("r_rx", 64'(resp_rx_has_msg_in_alt), 64'(v.hr));
        check("r_ch", 64'(resp_channel), 64'(v.ch_o));
        check("r_msg", 64'(resp_message), 64'(v.m_o));
        check("r_sp", 64'(resp_schedule_pid), 64'(v.s_pid));
        check("r_dp", 64'(resp_deschedule_pid), 64'(v.d_pid));
        if (!v.keep_fin) cc_finished = 1'b0;
      end
    end
    if (!got) check("resp_missing", 64'd0, 64'd1);
    step();
    check("resp_pulse", 64'(resp_valid), 64'd0);
    check("idle", 64'(busy), 64'd0);
  endtask

  // start an op on core 2 and reset the arbiter at cycle 'at'
  task automatic abort_at(input int at, input vec_t v);
    drive_req(v);
    #1;
    for (int w = 0; w < 8 && req_accept == '0; w++) step();
    check("ab_accept", 64'(req_accept), 64'(N'(1) << v.core));
    for (int t = 1; t <= at; t++) begin
      step();
      req_valid[v.core] = 1'b0;
    end
    check("ab_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_en", 64'(cc_enabled), 64'd0);
    step();
    step();
    check("ab_rv_rst", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    cc_finished = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      check("ab_no_resp", 64'(resp_valid), 64'd0);
    end
    cc_finished = 1'b0;
  endtask

  initial begin
    vec_t a, b;
    reset          = 1'b1;
    req_valid      = '0;
    req_op         = '0;
    req_channel    = '0;
    req_message    = '0;
    req_pid        = '0;
    req_rx_had_msg = '0;
    cc_finished    = 1'b0;
    cc_has_channel = 1'b0;
    cc_has_message = 1'b0;
    cc_has_schedule   = 1'b0;
    cc_has_deschedule = 1'b0;
    cc_rx_has_msg     = 1'b0;
    cc_channel_out    = '0;
    cc_schedule_pid   = '0;
    cc_deschedule_pid = '0;
    cc_message_out    = '0;

    vecs[0] = '{core:0, op:OP_CREATE_CHANNEL, chan:0, msg:0, pid:1,
                rx:0, fin:3, keep_fin:0, hc:1, hm:0, hs:0, hd:0, hr:0,
                ch_o:0, s_pid:0, d_pid:0, m_o:0};
    vecs[1] = '{core:1, op:OP_ENABLE_CHANNEL, chan:5, msg:16'h0021,
                pid:2, rx:0, fin:5, keep_fin:0, hc:0, hm:1, hs:0,
                hd:0, hr:1, ch_o:5, s_pid:0, d_pid:0, m_o:16'h0BEE};
    vecs[2] = '{core:2, op:OP_SEND, chan:0, msg:10, pid:4, rx:0, fin:3,
                keep_fin:1, hc:0, hm:0, hs:0, hd:1, hr:0, ch_o:0,
                s_pid:0, d_pid:4, m_o:0};
    vecs[3] = '{core:3, op:OP_ALT_START, chan:3, msg:0, pid:6, rx:1,
                fin:0, keep_fin:0, hc:0, hm:0, hs:1, hd:0, hr:1,
                ch_o:3, s_pid:3, d_pid:0, m_o:16'h0077};
    vecs[4] = '{core:0, op:OP_ALT_END, chan:9, msg:16'h1234, pid:7,
                rx:1, fin:4, keep_fin:0, hc:1, hm:1, hs:1, hd:1, hr:0,
                ch_o:9, s_pid:7, d_pid:2, m_o:16'h4321};
    vecs[5] = '{core:2, op:OP_RECEIVE, chan:1, msg:0, pid:5, rx:0,
                fin:3, keep_fin:0, hc:0, hm:0, hs:0, hd:0, hr:0,
                ch_o:0, s_pid:0, d_pid:0, m_o:0};

    #1;
    check("rst_accept", 64'(req_accept), 64'd0);
    check("rst_resp", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_en", 64'(cc_enabled), 64'd0);
    check("rst_op", 64'(cc_op), 64'd0);
    check("rst_hc", 64'(resp_has_channel), 64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 2; i++) do_op(vecs[i]);

    // rr_ptr is now 2: cores 1 and 3 together, 3 must win first
    a = '{core:3, op:OP_DESTROY_CHANNEL, chan:7, msg:0, pid:3, rx:0,
          fin:3, keep_fin:0, hc:0, hm:0, hs:0, hd:0, hr:0, ch_o:7,
          s_pid:0, d_pid:0, m_o:0};
    b = '{core:1, op:OP_RECEIVE, chan:7, msg:0, pid:2, rx:0, fin:4,
          keep_fin:0, hc:0, hm:1, hs:0, hd:0, hr:0, ch_o:7, s_pid:0,
          d_pid:0, m_o:16'h0055};
    drive_req(b);
    do_op(a);
    do_op(b);

    for (int i = 2; i < 4; i++) do_op(vecs[i]);

    abort_at(1, vecs[5]);
    abort_at(3, vecs[5]);
    do_op(vecs[4]);

`ifdef CHANNEL_ARB_TIMEOUT_EN
    begin
      int n;
      bit got;
      got = 1'b0;
      n = 0;
      drive_req(vecs[5]);
      #1;
      check("to_accept", 64'(req_accept), 64'(N'(1) << 2));
      step();
      req_valid[2] = 1'b0;
      for (n = 1; n < 70000 && !got; n++) begin
        step();
        if (resp_valid != '0) begin
          got = 1'b1;
          check("to_err", 64'(timeout_err), 64'd1);
          check("to_rv", 64'(resp_valid), 64'(N'(1) << 2));
          check("to_has", 64'({resp_has_channel, resp_has_message,
                resp_has_schedule, resp_has_deschedule,
                resp_rx_has_msg_in_alt}), 64'd0);
          check("to_late", 64'(n > 65535), 64'd1);
        end
      end
      if (!got) check("to_missing", 64'd0, 64'd1);
      step();
      check("to_pulse", 64'(timeout_err), 64'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
